// File: rtl/tx_arb_pkg.sv
// ---------------------------------------------------------------------------
// tx_arb_pkg
// Shared types and constants for the TX frame arbiter.
//   state_t      : arbiter FSM states
//   C_LEN_BITS   : width of the per-frame byte counter (11-bit frame count)
//   f_idx_bits() : width of a requester index, never less than 1
//   C_IDX_BITS   : index width for the default 4-requester configuration
// ---------------------------------------------------------------------------
package tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOF   = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int C_LEN_BITS = 11;

  function automatic int f_idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int C_IDX_BITS = f_idx_bits(4);

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches req starting at
// rr_ptr+1 and wrapping modulo P_NUM_REQ; rr_ptr itself has lowest priority.
//   req     : request vector
//   rr_ptr  : index of the most recently granted requester
//   found   : at least one request set
//   index   : winning requester index (0 when found is low)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int P_NUM_REQ  = 4,
  parameter int P_IDX_BITS = 2
) (
  input  logic [P_NUM_REQ-1:0]  req,
  input  logic [P_IDX_BITS-1:0] rr_ptr,
  output logic                  found,
  output logic [P_IDX_BITS-1:0] index
);

  int                  pos;
  logic [P_IDX_BITS-1:0] pos_idx;

  // Walk from the farthest offset down to the nearest one so that the
  // nearest set bit after rr_ptr overwrites any earlier hit.
  always_comb begin
    found   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int off = P_NUM_REQ; off >= 1; off--) begin
      pos     = (int'(rr_ptr) + off) % P_NUM_REQ;
      pos_idx = P_IDX_BITS'(pos);
      if (req[pos_idx]) begin
        found = 1'b1;
        index = pos_idx;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tx_frame_arbiter
// Shares the TX FIFO write port between P_NUM_REQ frame sources, one whole
// frame at a time, with round-robin selection at frame boundaries, a fixed
// inter-frame gap after every tx_eof, and truncation of oversize frames.
//   clk, rst_n           : FIFO write clock, async active-low reset
//   req_sof/req_eof      : per-source frame request (level) / end pulse
//   req_byte/_vld/_rdy   : per-source byte stream, source i in [8i+7:8i]
//   req_grant            : one-hot ownership of the write port
//   tx_sof/tx_eof        : frame delimiters to the FIFO writer
//   tx_byte/_vld/_rdy    : byte stream to the FIFO writer
//   err_oversize         : pulse when a frame is cut at P_MAX_LEN
//   frm_cnt              : frames emitted (wrapping)
//   busy                 : arbiter not idle
// ---------------------------------------------------------------------------
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int P_NUM_REQ    = 4,
  parameter int P_MAX_LEN    = 1514,
  parameter int P_GAP_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [P_NUM_REQ-1:0]   req_sof,
  input  logic [P_NUM_REQ-1:0]   req_eof,
  input  logic [8*P_NUM_REQ-1:0] req_byte,
  input  logic [P_NUM_REQ-1:0]   req_byte_vld,
  output logic [P_NUM_REQ-1:0]   req_byte_rdy,
  output logic [P_NUM_REQ-1:0]   req_grant,
  output logic                   tx_sof,
  output logic                   tx_eof,
  output logic [7:0]             tx_byte,
  output logic                   tx_byte_vld,
  input  logic                   tx_byte_rdy,
  output logic                   err_oversize,
  output logic [15:0]            frm_cnt,
  output logic                   busy
);

  localparam int C_IW = f_idx_bits(P_NUM_REQ);
  localparam int C_GW = $clog2(P_GAP_CYCLES + 1);
  localparam logic [C_LEN_BITS-1:0] C_MAX      = C_LEN_BITS'(P_MAX_LEN);
  localparam logic [C_GW-1:0]       C_GAP_LAST = C_GW'(P_GAP_CYCLES - 1);

  state_t                state_reg, state_next;
  logic [C_IW-1:0]       g_reg, g_next;
  logic [C_IW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [C_LEN_BITS-1:0] cnt_reg, cnt_next;
  logic [C_GW-1:0]       gap_reg, gap_next;
  logic [15:0]           frm_cnt_reg, frm_cnt_next;

  logic                  pick_found;
  logic [C_IW-1:0]       pick_idx;

  logic [7:0]            byte_arr [P_NUM_REQ];
  logic [7:0]            sel_byte;
  logic                  sel_vld;
  logic                  sel_eof;
  logic                  grant_act;
  logic                  rdy_act;
  logic                  room;

  // Per-source fan-in and one-hot fan-out around the granted index.
  generate
    for (genvar gi = 0; gi < P_NUM_REQ; gi++) begin : g_src
      assign byte_arr[gi]     = req_byte[8*gi +: 8];
      assign req_grant[gi]    = grant_act & (g_reg == C_IW'(gi));
      assign req_byte_rdy[gi] = rdy_act   & (g_reg == C_IW'(gi));
    end
  endgenerate

  assign sel_byte = byte_arr[g_reg];
  assign sel_vld  = req_byte_vld[g_reg];
  assign sel_eof  = req_eof[g_reg];
  assign room     = (cnt_reg < C_MAX);

  rr_pick #(
    .P_NUM_REQ  (P_NUM_REQ),
    .P_IDX_BITS (C_IW)
  ) u_rr_pick (
    .req    (req_sof),
    .rr_ptr (rr_ptr_reg),
    .found  (pick_found),
    .index  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      g_reg       <= '0;
      rr_ptr_reg  <= C_IW'(P_NUM_REQ - 1);
      cnt_reg     <= '0;
      gap_reg     <= '0;
      frm_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      g_reg       <= g_next;
      rr_ptr_reg  <= rr_ptr_next;
      cnt_reg     <= cnt_next;
      gap_reg     <= gap_next;
      frm_cnt_reg <= frm_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    g_next       = g_reg;
    rr_ptr_next  = rr_ptr_reg;
    cnt_next     = cnt_reg;
    gap_next     = gap_reg;
    frm_cnt_next = frm_cnt_reg;
    grant_act    = 1'b0;
    rdy_act      = 1'b0;
    tx_sof       = 1'b0;
    tx_eof       = 1'b0;
    tx_byte      = 8'h00;
    tx_byte_vld  = 1'b0;
    err_oversize = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (pick_found) begin
          g_next      = pick_idx;
          rr_ptr_next = pick_idx;
          state_next  = SOF;
        end
      end

      SOF: begin
        tx_sof     = 1'b1;
        grant_act  = 1'b1;
        cnt_next   = '0;
        state_next = DATA;
      end

      DATA: begin
        grant_act   = 1'b1;
        tx_byte     = sel_byte;
        // Once the length limit is hit the source is stalled, so the
        // writer must not see a valid byte that nobody is consuming.
        tx_byte_vld = sel_vld & ~sel_eof & room;
        rdy_act     = tx_byte_rdy & ~sel_eof & room;
        if (sel_eof) begin
          tx_eof       = 1'b1;
          frm_cnt_next = frm_cnt_reg + 16'd1;
          gap_next     = '0;
          state_next   = GAP;
        end else if (!room) begin
          tx_eof       = 1'b1;
          err_oversize = 1'b1;
          frm_cnt_next = frm_cnt_reg + 16'd1;
          state_next   = DRAIN;
        end else if (sel_vld && tx_byte_rdy) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DRAIN: begin
        // The frame is already closed downstream; swallow the remainder.
        grant_act = 1'b1;
        rdy_act   = 1'b1;
        if (sel_eof) begin
          gap_next   = '0;
          state_next = GAP;
        end
      end

      GAP: begin
        if (gap_reg == C_GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign frm_cnt = frm_cnt_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tx_frame_arbiter
// Directed bench for tx_frame_arbiter with 4 sources, an 8-byte length
// limit and a 4-cycle gap. Inputs change 2 time units after each rising
// edge and outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_tx_frame_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_sof = '0;
  logic [N-1:0]   req_eof = '0;
  logic [8*N-1:0] req_byte = '0;
  logic [N-1:0]   req_byte_vld = '0;
  logic           tx_byte_rdy = 1'b0;
  logic [N-1:0]   req_byte_rdy;
  logic [N-1:0]   req_grant;
  logic           tx_sof;
  logic           tx_eof;
  logic [7:0]     tx_byte;
  logic           tx_byte_vld;
  logic           err_oversize;
  logic [15:0]    frm_cnt;
  logic           busy;

  int n_assert = 0;
  int n_fail   = 0;

  tx_frame_arbiter #(
    .P_NUM_REQ    (N),
    .P_MAX_LEN    (8),
    .P_GAP_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_sof      (req_sof),
    .req_eof      (req_eof),
    .req_byte     (req_byte),
    .req_byte_vld (req_byte_vld),
    .req_byte_rdy (req_byte_rdy),
    .req_grant    (req_grant),
    .tx_sof       (tx_sof),
    .tx_eof       (tx_eof),
    .tx_byte      (tx_byte),
    .tx_byte_vld  (tx_byte_vld),
    .tx_byte_rdy  (tx_byte_rdy),
    .err_oversize (err_oversize),
    .frm_cnt      (frm_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(req_grant), 0);
    chk({tag, "_rdy"},   32'(req_byte_rdy), 0);
    chk({tag, "_sof"},   32'(tx_sof), 0);
    chk({tag, "_eof"},   32'(tx_eof), 0);
    chk({tag, "_byte"},  32'(tx_byte), 0);
    chk({tag, "_vld"},   32'(tx_byte_vld), 0);
    chk({tag, "_err"},   32'(err_oversize), 0);
    chk({tag, "_frm"},   32'(frm_cnt), 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  // Waits (bounded) for tx_sof and checks the grant belongs to src.
  task automatic wait_sof(input int src);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tx_sof === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cyc();
      #1;
    end
    chk("sof_seen",      32'(seen), 1);
    chk("sof_grant",     32'(req_grant), 32'(1 << src));
    chk("sof_no_vld",    32'(tx_byte_vld), 0);
    chk("sof_byte_zero", 32'(tx_byte), 0);
    req_sof[src] = 1'b0;
  endtask

  // Streams n bytes base, base+1, ... with tx_byte_rdy held high, then eof.
  task automatic send_frame(input int src, input int n, input logic [7:0] base,
                            input logic eof_vld);
    for (int i = 0; i < n; i++) begin
      cyc();
      req_byte[src*8 +: 8] = base + 8'(i);
      req_byte_vld[src] = 1'b1;
      tx_byte_rdy = 1'b1;
      #1;
      chk("data_byte",  32'(tx_byte), 32'(base + 8'(i)));
      chk("data_vld",   32'(tx_byte_vld), 1);
      chk("data_rdy",   32'(req_byte_rdy), 32'(1 << src));
      chk("data_grant", 32'(req_grant), 32'(1 << src));
    end
    cyc();
    req_byte_vld[src] = eof_vld;
    req_eof[src] = 1'b1;
    #1;
    chk("eof_pulse", 32'(tx_eof), 1);
    chk("eof_novld", 32'(tx_byte_vld), 0);
    chk("eof_nordy", 32'(req_byte_rdy), 0);
    chk("eof_noerr", 32'(err_oversize), 0);
    cyc();
    req_eof[src] = 1'b0;
    req_byte_vld[src] = 1'b0;
    #1;
    chk("gap_noeof",  32'(tx_eof), 0);
    chk("gap_busy",   32'(busy), 1);
    chk("gap_nogrnt", 32'(req_grant), 0);
    $display("frame src%0d len %0d done, frm_cnt=%0d", src, n, frm_cnt);
  endtask

  initial begin
    int idx;
    int k;

    // Reset state
    #1;
    chk_all_zero("reset");

    // Single source, 4 bytes, gap timing
    cyc();
    rst_n = 1'b1;
    req_sof[0] = 1'b1;
    #1;
    chk("idle_busy",  32'(busy), 0);
    chk("idle_grant", 32'(req_grant), 0);
    chk("idle_sof",   32'(tx_sof), 0);
    cyc();
    #1;
    chk("decide_1cyc", 32'(tx_sof), 1);
    wait_sof(0);
    send_frame(0, 4, 8'hA1, 1'b0);
    chk("single_frm", 32'(frm_cnt), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("gap_hold", 32'(busy), 1);
      chk("gap_nosof", 32'(tx_sof), 0);
    end
    cyc();
    #1;
    chk("gap_to_idle", 32'(busy), 0);

    // Contention from reset: 0, 2, 3 then re-requesting 0
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_frm", 32'(frm_cnt), 0);
    cyc();
    rst_n = 1'b1;
    req_sof = 4'b1101;
    #1;
    wait_sof(0);
    send_frame(0, 2, 8'h10, 1'b0);
    req_sof[0] = 1'b1;
    wait_sof(2);
    send_frame(2, 2, 8'h20, 1'b0);
    wait_sof(3);
    send_frame(3, 2, 8'h30, 1'b0);
    wait_sof(0);
    send_frame(0, 1, 8'h40, 1'b0);
    chk("contend_frm", 32'(frm_cnt), 4);

    // Backpressure: 6 bytes from src1, tx_byte_rdy toggling
    req_sof[1] = 1'b1;
    wait_sof(1);
    idx = 0;
    k = 0;
    while (idx < 6 && k < 30) begin
      cyc();
      tx_byte_rdy = (k % 2 == 0);
      req_byte[15:8] = 8'h60 + 8'(idx);
      req_byte_vld[1] = 1'b1;
      #1;
      chk("bp_rdy_mirror", 32'(req_byte_rdy), 32'(tx_byte_rdy) << 1);
      chk("bp_byte", 32'(tx_byte), 32'(8'h60 + 8'(idx)));
      if (tx_byte_vld && tx_byte_rdy) idx++;
      k++;
    end
    chk("bp_count", 32'(idx), 6);
    cyc();
    tx_byte_rdy = 1'b1;
    req_byte_vld[1] = 1'b0;
    req_eof[1] = 1'b1;
    #1;
    chk("bp_eof", 32'(tx_eof), 1);
    cyc();
    req_eof[1] = 1'b0;
    #1;
    chk("bp_frm", 32'(frm_cnt), 5);
    $display("frame src1 len 6 backpressured done, frm_cnt=%0d", frm_cnt);

    // Oversize: src2 streams 12 bytes against an 8-byte limit
    req_sof[2] = 1'b1;
    wait_sof(2);
    for (int i = 0; i < 8; i++) begin
      cyc();
      req_byte[23:16] = 8'h80 + 8'(i);
      req_byte_vld[2] = 1'b1;
      #1;
      chk("ovs_byte",  32'(tx_byte), 32'(8'h80 + 8'(i)));
      chk("ovs_rdy",   32'(req_byte_rdy), 32'h4);
      chk("ovs_noeof", 32'(tx_eof), 0);
    end
    cyc();
    req_byte[23:16] = 8'h88;
    #1;
    chk("ovs_eof",   32'(tx_eof), 1);
    chk("ovs_err",   32'(err_oversize), 1);
    chk("ovs_novld", 32'(tx_byte_vld), 0);
    chk("ovs_nordy", 32'(req_byte_rdy), 0);
    for (int i = 8; i < 12; i++) begin
      cyc();
      req_byte[23:16] = 8'h80 + 8'(i);
      #1;
      chk("drain_rdy",   32'(req_byte_rdy), 32'h4);
      chk("drain_grant", 32'(req_grant), 32'h4);
      chk("drain_novld", 32'(tx_byte_vld), 0);
      chk("drain_noeof", 32'(tx_eof), 0);
      chk("drain_noerr", 32'(err_oversize), 0);
    end
    cyc();
    req_byte_vld[2] = 1'b0;
    req_eof[2] = 1'b1;
    #1;
    chk("drain_end_noeof", 32'(tx_eof), 0);
    cyc();
    req_eof[2] = 1'b0;
    #1;
    chk("drain_gap_busy",  32'(busy), 1);
    chk("drain_gap_grant", 32'(req_grant), 0);
    chk("ovs_frm",         32'(frm_cnt), 6);
    $display("frame src2 len 12 truncated to 8, frm_cnt=%0d", frm_cnt);

    // Zero-length frame with vld asserted alongside eof
    req_sof[3] = 1'b1;
    wait_sof(3);
    send_frame(3, 0, 8'h00, 1'b1);
    chk("zero_frm", 32'(frm_cnt), 7);

    // Reset mid-frame, then a pending src1 request
    req_sof[0] = 1'b1;
    wait_sof(0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      req_byte[7:0] = 8'hC0 + 8'(i);
      req_byte_vld[0] = 1'b1;
      #1;
      chk("mid_byte", 32'(tx_byte), 32'(8'hC0 + 8'(i)));
    end
    cyc();
    req_byte[7:0] = 8'hC3;
    rst_n = 1'b0;
    req_sof[1] = 1'b1;
    #1;
    chk_all_zero("midrst");
    cyc();
    rst_n = 1'b1;
    req_byte_vld[0] = 1'b0;
    #1;
    chk("midrst_idle", 32'(busy), 0);
    wait_sof(1);
    send_frame(1, 2, 8'h70, 1'b0);
    chk("midrst_frm", 32'(frm_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
